// File: rtl/rv_pipe_front_regs.sv
// Purpose : IF/ID, ID/EX and EX/MEM pipeline registers of the 5-stage RV32 core.
// Latency : one clk per stage; no combinational input->output paths.
// Backpressure: ifid_stall holds IF/ID, idex_bubble zeroes ID/EX, EX/MEM always loads.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   ifid_*_in / _out   fetch PC + instruction word, held while ifid_stall=1
//   idex_*_in / _out   decoded operands/immediate/opcode/id, zeroed by idex_bubble
//   exmem_*_in / _out  execute results, captured every cycle
//
// Build option: define IFID_FLUSH_EN to add the ifid_flush input, which loads
// NOP_INSTR into IF/ID (with the incoming PC) and overrides ifid_stall.

module rv_pipe_front_regs #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    // IF/ID
    input  logic [XLEN-1:0] ifid_pc_in,
    input  logic [XLEN-1:0] ifid_instr_in,
    input  logic            ifid_stall,
`ifdef IFID_FLUSH_EN
    input  logic            ifid_flush,
`endif
    output logic [XLEN-1:0] ifid_pc_out,
    output logic [XLEN-1:0] ifid_instr_out,
    // ID/EX
    input  logic            idex_rs1_valid_in,
    input  logic            idex_rs2_valid_in,
    input  logic            idex_rd_valid_in,
    input  logic [4:0]      idex_rs1_addr_in,
    input  logic [4:0]      idex_rs2_addr_in,
    input  logic [4:0]      idex_rd_addr_in,
    input  logic [XLEN-1:0] idex_imm_in,
    input  logic [XLEN-1:0] idex_pc_in,
    input  logic [XLEN-1:0] idex_rs1_value_in,
    input  logic [XLEN-1:0] idex_rs2_value_in,
    input  logic [6:0]      idex_opcode_in,
    input  logic [5:0]      idex_instr_id_in,
    input  logic            idex_bubble,
    output logic            idex_rs1_valid_out,
    output logic            idex_rs2_valid_out,
    output logic            idex_rd_valid_out,
    output logic [4:0]      idex_rs1_addr_out,
    output logic [4:0]      idex_rs2_addr_out,
    output logic [4:0]      idex_rd_addr_out,
    output logic [XLEN-1:0] idex_imm_out,
    output logic [XLEN-1:0] idex_pc_out,
    output logic [XLEN-1:0] idex_rs1_value_out,
    output logic [XLEN-1:0] idex_rs2_value_out,
    output logic [6:0]      idex_opcode_out,
    output logic [5:0]      idex_instr_id_out,
    // EX/MEM
    input  logic [4:0]      exmem_rs1_addr_in,
    input  logic [4:0]      exmem_rs2_addr_in,
    input  logic [4:0]      exmem_rd_addr_in,
    input  logic            exmem_rd_valid_in,
    input  logic [XLEN-1:0] exmem_rs1_value_in,
    input  logic [XLEN-1:0] exmem_rs2_value_in,
    input  logic [XLEN-1:0] exmem_pc_in,
    input  logic [XLEN-1:0] exmem_mem_addr_in,
    input  logic [XLEN-1:0] exmem_exec_output_in,
    input  logic [XLEN-1:0] exmem_jump_addr_in,
    input  logic            exmem_jump_signal_in,
    input  logic [5:0]      exmem_instr_id_in,
    output logic [4:0]      exmem_rs1_addr_out,
    output logic [4:0]      exmem_rs2_addr_out,
    output logic [4:0]      exmem_rd_addr_out,
    output logic            exmem_rd_valid_out,
    output logic [XLEN-1:0] exmem_rs1_value_out,
    output logic [XLEN-1:0] exmem_rs2_value_out,
    output logic [XLEN-1:0] exmem_pc_out,
    output logic [XLEN-1:0] exmem_mem_addr_out,
    output logic [XLEN-1:0] exmem_exec_output_out,
    output logic [XLEN-1:0] exmem_jump_addr_out,
    output logic            exmem_jump_signal_out,
    output logic [5:0]      exmem_instr_id_out
);

    typedef struct packed {
        logic            rs1_valid;
        logic            rs2_valid;
        logic            rd_valid;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_value;
        logic [XLEN-1:0] rs2_value;
        logic [6:0]      opcode;
        logic [5:0]      instr_id;
    } idex_t;

    typedef struct packed {
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic            rd_valid;
        logic [XLEN-1:0] rs1_value;
        logic [XLEN-1:0] rs2_value;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] mem_addr;
        logic [XLEN-1:0] exec_output;
        logic [XLEN-1:0] jump_addr;
        logic            jump_signal;
        logic [5:0]      instr_id;
    } exmem_t;

    logic [XLEN-1:0] r_ifid_pc;
    logic [XLEN-1:0] r_ifid_instr;
    idex_t           r_idex;
    exmem_t          r_exmem;
    idex_t           w_idex_in;
    exmem_t          w_exmem_in;
    logic            w_ifid_flush;

`ifdef IFID_FLUSH_EN
    assign w_ifid_flush = ifid_flush;
`else
    assign w_ifid_flush = 1'b0;
`endif

    assign w_idex_in = '{
        rs1_valid: idex_rs1_valid_in, rs2_valid: idex_rs2_valid_in,
        rd_valid:  idex_rd_valid_in,
        rs1_addr:  idex_rs1_addr_in,  rs2_addr:  idex_rs2_addr_in,
        rd_addr:   idex_rd_addr_in,
        imm:       idex_imm_in,       pc:        idex_pc_in,
        rs1_value: idex_rs1_value_in, rs2_value: idex_rs2_value_in,
        opcode:    idex_opcode_in,    instr_id:  idex_instr_id_in
    };

    assign w_exmem_in = '{
        rs1_addr:    exmem_rs1_addr_in,    rs2_addr:  exmem_rs2_addr_in,
        rd_addr:     exmem_rd_addr_in,     rd_valid:  exmem_rd_valid_in,
        rs1_value:   exmem_rs1_value_in,   rs2_value: exmem_rs2_value_in,
        pc:          exmem_pc_in,          mem_addr:  exmem_mem_addr_in,
        exec_output: exmem_exec_output_in, jump_addr: exmem_jump_addr_in,
        jump_signal: exmem_jump_signal_in, instr_id:  exmem_instr_id_in
    };

    // IF/ID: flush wins over stall so a redirect is never lost behind a hazard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ifid_pc    <= '0;
            r_ifid_instr <= NOP_INSTR;
        end else if (w_ifid_flush) begin
            r_ifid_pc    <= ifid_pc_in;
            r_ifid_instr <= NOP_INSTR;
        end else if (!ifid_stall) begin
            r_ifid_pc    <= ifid_pc_in;
            r_ifid_instr <= ifid_instr_in;
        end
    end

    // ID/EX: a bubble is all-zero; instr_id 0 means "no instruction" downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idex <= '0;
        end else if (idex_bubble) begin
            r_idex <= '0;
        end else begin
            r_idex <= w_idex_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exmem <= '0;
        end else begin
            r_exmem <= w_exmem_in;
        end
    end

    assign ifid_pc_out           = r_ifid_pc;
    assign ifid_instr_out        = r_ifid_instr;

    assign idex_rs1_valid_out    = r_idex.rs1_valid;
    assign idex_rs2_valid_out    = r_idex.rs2_valid;
    assign idex_rd_valid_out     = r_idex.rd_valid;
    assign idex_rs1_addr_out     = r_idex.rs1_addr;
    assign idex_rs2_addr_out     = r_idex.rs2_addr;
    assign idex_rd_addr_out      = r_idex.rd_addr;
    assign idex_imm_out          = r_idex.imm;
    assign idex_pc_out           = r_idex.pc;
    assign idex_rs1_value_out    = r_idex.rs1_value;
    assign idex_rs2_value_out    = r_idex.rs2_value;
    assign idex_opcode_out       = r_idex.opcode;
    assign idex_instr_id_out     = r_idex.instr_id;

    assign exmem_rs1_addr_out    = r_exmem.rs1_addr;
    assign exmem_rs2_addr_out    = r_exmem.rs2_addr;
    assign exmem_rd_addr_out     = r_exmem.rd_addr;
    assign exmem_rd_valid_out    = r_exmem.rd_valid;
    assign exmem_rs1_value_out   = r_exmem.rs1_value;
    assign exmem_rs2_value_out   = r_exmem.rs2_value;
    assign exmem_pc_out          = r_exmem.pc;
    assign exmem_mem_addr_out    = r_exmem.mem_addr;
    assign exmem_exec_output_out = r_exmem.exec_output;
    assign exmem_jump_addr_out   = r_exmem.jump_addr;
    assign exmem_jump_signal_out = r_exmem.jump_signal;
    assign exmem_instr_id_out    = r_exmem.instr_id;

endmodule

// File: tb/tb_rv_pipe_front_regs.sv
// Bench for rv_pipe_front_regs: directed scenarios followed by a randomized run,
// compared against a stage-level reference model of the three registers.
module tb_rv_pipe_front_regs;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct packed {
        logic        rs1_valid, rs2_valid, rd_valid;
        logic [4:0]  rs1_addr, rs2_addr, rd_addr;
        logic [31:0] imm, pc, rs1_value, rs2_value;
        logic [6:0]  opcode;
        logic [5:0]  instr_id;
    } idex_s;

    typedef struct packed {
        logic [4:0]  rs1_addr, rs2_addr, rd_addr;
        logic        rd_valid;
        logic [31:0] rs1_value, rs2_value, pc, mem_addr, exec_output, jump_addr;
        logic        jump_signal;
        logic [5:0]  instr_id;
    } exmem_s;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifid_pc_in, ifid_instr_in;
    logic        ifid_stall, ifid_flush, idex_bubble;
    idex_s       idex_in;
    exmem_s      exmem_in;

    logic [31:0] ifid_pc_out, ifid_instr_out;
    logic        idex_rs1_valid_out, idex_rs2_valid_out, idex_rd_valid_out;
    logic [4:0]  idex_rs1_addr_out, idex_rs2_addr_out, idex_rd_addr_out;
    logic [31:0] idex_imm_out, idex_pc_out, idex_rs1_value_out, idex_rs2_value_out;
    logic [6:0]  idex_opcode_out;
    logic [5:0]  idex_instr_id_out;
    logic [4:0]  exmem_rs1_addr_out, exmem_rs2_addr_out, exmem_rd_addr_out;
    logic        exmem_rd_valid_out, exmem_jump_signal_out;
    logic [31:0] exmem_rs1_value_out, exmem_rs2_value_out, exmem_pc_out;
    logic [31:0] exmem_mem_addr_out, exmem_exec_output_out, exmem_jump_addr_out;
    logic [5:0]  exmem_instr_id_out;

    idex_s       idex_obs;
    exmem_s      exmem_obs;

    // Reference state
    logic [31:0] e_pc, e_instr;
    idex_s       e_idex;
    exmem_s      e_exmem;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv_pipe_front_regs dut (
        .clk(clk), .rst(rst),
        .ifid_pc_in(ifid_pc_in), .ifid_instr_in(ifid_instr_in), .ifid_stall(ifid_stall),
`ifdef IFID_FLUSH_EN
        .ifid_flush(ifid_flush),
`endif
        .ifid_pc_out(ifid_pc_out), .ifid_instr_out(ifid_instr_out),
        .idex_rs1_valid_in(idex_in.rs1_valid), .idex_rs2_valid_in(idex_in.rs2_valid),
        .idex_rd_valid_in(idex_in.rd_valid),
        .idex_rs1_addr_in(idex_in.rs1_addr), .idex_rs2_addr_in(idex_in.rs2_addr),
        .idex_rd_addr_in(idex_in.rd_addr),
        .idex_imm_in(idex_in.imm), .idex_pc_in(idex_in.pc),
        .idex_rs1_value_in(idex_in.rs1_value), .idex_rs2_value_in(idex_in.rs2_value),
        .idex_opcode_in(idex_in.opcode), .idex_instr_id_in(idex_in.instr_id),
        .idex_bubble(idex_bubble),
        .idex_rs1_valid_out(idex_rs1_valid_out), .idex_rs2_valid_out(idex_rs2_valid_out),
        .idex_rd_valid_out(idex_rd_valid_out),
        .idex_rs1_addr_out(idex_rs1_addr_out), .idex_rs2_addr_out(idex_rs2_addr_out),
        .idex_rd_addr_out(idex_rd_addr_out),
        .idex_imm_out(idex_imm_out), .idex_pc_out(idex_pc_out),
        .idex_rs1_value_out(idex_rs1_value_out), .idex_rs2_value_out(idex_rs2_value_out),
        .idex_opcode_out(idex_opcode_out), .idex_instr_id_out(idex_instr_id_out),
        .exmem_rs1_addr_in(exmem_in.rs1_addr), .exmem_rs2_addr_in(exmem_in.rs2_addr),
        .exmem_rd_addr_in(exmem_in.rd_addr), .exmem_rd_valid_in(exmem_in.rd_valid),
        .exmem_rs1_value_in(exmem_in.rs1_value), .exmem_rs2_value_in(exmem_in.rs2_value),
        .exmem_pc_in(exmem_in.pc), .exmem_mem_addr_in(exmem_in.mem_addr),
        .exmem_exec_output_in(exmem_in.exec_output), .exmem_jump_addr_in(exmem_in.jump_addr),
        .exmem_jump_signal_in(exmem_in.jump_signal), .exmem_instr_id_in(exmem_in.instr_id),
        .exmem_rs1_addr_out(exmem_rs1_addr_out), .exmem_rs2_addr_out(exmem_rs2_addr_out),
        .exmem_rd_addr_out(exmem_rd_addr_out), .exmem_rd_valid_out(exmem_rd_valid_out),
        .exmem_rs1_value_out(exmem_rs1_value_out), .exmem_rs2_value_out(exmem_rs2_value_out),
        .exmem_pc_out(exmem_pc_out), .exmem_mem_addr_out(exmem_mem_addr_out),
        .exmem_exec_output_out(exmem_exec_output_out), .exmem_jump_addr_out(exmem_jump_addr_out),
        .exmem_jump_signal_out(exmem_jump_signal_out), .exmem_instr_id_out(exmem_instr_id_out)
    );

    assign idex_obs = {idex_rs1_valid_out, idex_rs2_valid_out, idex_rd_valid_out,
                       idex_rs1_addr_out, idex_rs2_addr_out, idex_rd_addr_out,
                       idex_imm_out, idex_pc_out, idex_rs1_value_out, idex_rs2_value_out,
                       idex_opcode_out, idex_instr_id_out};
    assign exmem_obs = {exmem_rs1_addr_out, exmem_rs2_addr_out, exmem_rd_addr_out,
                        exmem_rd_valid_out, exmem_rs1_value_out, exmem_rs2_value_out,
                        exmem_pc_out, exmem_mem_addr_out, exmem_exec_output_out,
                        exmem_jump_addr_out, exmem_jump_signal_out, exmem_instr_id_out};

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ":ifid_pc"},    256'(ifid_pc_out),    256'(e_pc));
        check({tag, ":ifid_instr"}, 256'(ifid_instr_out), 256'(e_instr));
        check({tag, ":idex"},       256'(idex_obs),       256'(e_idex));
        check({tag, ":exmem"},      256'(exmem_obs),      256'(e_exmem));
    endtask

    task automatic model_reset();
        e_pc    = '0;
        e_instr = NOP;
        e_idex  = '0;
        e_exmem = '0;
    endtask

    // Stage behaviour on a rising edge, from the inputs present at that edge.
    task automatic model_edge();
        logic fl;
        fl = 1'b0;
`ifdef IFID_FLUSH_EN
        fl = ifid_flush;
`endif
        if (fl) begin
            e_pc    = ifid_pc_in;
            e_instr = NOP;
        end else if (!ifid_stall) begin
            e_pc    = ifid_pc_in;
            e_instr = ifid_instr_in;
        end
        e_idex  = idex_bubble ? idex_s'('0) : idex_in;
        e_exmem = exmem_in;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        logic [255:0] r;
        rst           = 1'b1;
        ifid_pc_in    = '0;
        ifid_instr_in = '0;
        ifid_stall    = 1'b0;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        idex_in       = '0;
        exmem_in      = '0;
        model_reset();

        // Reset state, including across a clock edge while reset is held.
        #3;  check_all("reset");
        ifid_pc_in = 32'h1234; ifid_instr_in = 32'hFFFF_FFFF; exmem_in.pc = 32'h55;
        #4;  check_all("reset_held");
        #1;  rst = 1'b0;
        ifid_pc_in = '0; ifid_instr_in = '0; exmem_in = '0;

        // IF/ID load, then stall hold.
        ifid_pc_in = 32'h100; ifid_instr_in = 32'h00500093;
        step("ifid_load");
        check("ifid_pc_0x100",   256'(ifid_pc_out),    256'(32'h100));
        check("ifid_instr_addi", 256'(ifid_instr_out), 256'(32'h00500093));
        ifid_stall = 1'b1; ifid_pc_in = 32'h104; ifid_instr_in = 32'h00100113;
        step("ifid_stall");
        check("ifid_stall_pc", 256'(ifid_pc_out), 256'(32'h100));
        ifid_stall = 1'b0;

        // ID/EX pass-through, then bubble.
        idex_in = '0;
        idex_in.rd_addr = 5'd5; idex_in.rd_valid = 1'b1;
        idex_in.imm = 32'hFFFFFFFC; idex_in.instr_id = 6'd3; idex_in.opcode = 7'h13;
        step("idex_load");
        check("idex_rd_addr",  256'(idex_rd_addr_out),  256'(5));
        check("idex_rd_valid", 256'(idex_rd_valid_out), 256'(1));
        check("idex_imm",      256'(idex_imm_out),      256'(32'hFFFFFFFC));
        check("idex_id",       256'(idex_instr_id_out), 256'(3));
        idex_bubble = 1'b1;
        step("idex_bubble");
        check("bubble_rd_valid", 256'(idex_rd_valid_out), 256'(0));
        check("bubble_id",       256'(idex_instr_id_out), 256'(0));
        check("bubble_imm",      256'(idex_imm_out),      256'(0));
        idex_bubble = 1'b0;

        // Load-use: IF/ID holds while ID/EX takes a bubble, then the held word advances.
        ifid_pc_in = 32'h108; ifid_instr_in = 32'h0000A183;
        step("lu_setup");
        ifid_stall = 1'b1; idex_bubble = 1'b1;
        ifid_pc_in = 32'h10C; ifid_instr_in = 32'h00318233;
        step("lu_hold");
        check("lu_instr_held", 256'(ifid_instr_out),    256'(32'h0000A183));
        check("lu_idex_id",    256'(idex_instr_id_out), 256'(0));
        ifid_stall = 1'b0; idex_bubble = 1'b0;
        step("lu_release");
        check("lu_instr_adv", 256'(ifid_instr_out), 256'(32'h00318233));

        // EX/MEM capture and tracking.
        exmem_in.exec_output = 32'hDEADBEEF; exmem_in.jump_signal = 1'b1;
        exmem_in.jump_addr = 32'h40;
        step("exmem_load");
        check("exmem_exec",  256'(exmem_exec_output_out), 256'(32'hDEADBEEF));
        check("exmem_jsig",  256'(exmem_jump_signal_out), 256'(1));
        check("exmem_jaddr", 256'(exmem_jump_addr_out),   256'(32'h40));
        exmem_in.exec_output = 32'h0BADF00D; exmem_in.jump_signal = 1'b0;
        step("exmem_track");
        check("exmem_exec2", 256'(exmem_exec_output_out), 256'(32'h0BADF00D));

`ifdef IFID_FLUSH_EN
        ifid_flush = 1'b1; ifid_stall = 1'b1;
        ifid_pc_in = 32'h200; ifid_instr_in = 32'h00700393;
        step("flush");
        check("flush_instr", 256'(ifid_instr_out), 256'(32'h13));
        check("flush_pc",    256'(ifid_pc_out),    256'(32'h200));
        ifid_flush = 1'b0; ifid_stall = 1'b0;
`endif

        // Randomized run.
        for (int n = 0; n < 300; n++) begin
            ifid_pc_in    = $urandom;
            ifid_instr_in = $urandom;
            ifid_stall    = ($urandom_range(3) == 0);
            idex_bubble   = ($urandom_range(3) == 0);
`ifdef IFID_FLUSH_EN
            ifid_flush    = ($urandom_range(7) == 0);
`endif
            r = rand256(); idex_in  = r[$bits(idex_s)-1:0];
            r = rand256(); exmem_in = r[$bits(exmem_s)-1:0];
            step("rand");
        end

        // Asynchronous reset mid-cycle with live state.
        ifid_stall = 1'b0; idex_bubble = 1'b0; ifid_flush = 1'b0;
        #2; rst = 1'b1;
        model_reset();
        #1; check_all("async_rst");
        #2; rst = 1'b0;
        #1; check_all("rst_release");
        step("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
